// File: rtl/bht_port_ctrl.sv
// -----------------------------------------------------------------------------
// bht_port_ctrl
// Sequencer/arbiter for a single-port array of 2-bit saturating branch
// counters with a 1-cycle synchronous read. After reset it clears the whole
// array to 2'b00. It then shares the port between fetch lookups and a small
// FIFO of retire updates. Each update is a two-cycle read-modify-write.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   lkp_valid_i/lkp_idx_i      fetch lookup request
//   lkp_ready_o                lookup accepted this cycle (with lkp_valid_i)
//   pred_valid_o/pred_taken_o  prediction, one cycle after acceptance
//   upd_valid_i/upd_idx_i/
//   upd_taken_i                retire update request
//   upd_ready_o                update queue not full
//   init_done_o                clear sweep finished
//   tbl_en_o/tbl_we_o/
//   tbl_idx_o/tbl_wdata_o      storage port command
//   tbl_rdata_i                storage read data (cycle after a read)
// -----------------------------------------------------------------------------
`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 10
`endif

module bht_port_ctrl #(
   parameter int IDX_W    = `BHT_IDX_WIDTH,
   parameter int UQ_DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             lkp_valid_i,
   input  logic [IDX_W-1:0] lkp_idx_i,
   output logic             lkp_ready_o,
   output logic             pred_valid_o,
   output logic             pred_taken_o,
   input  logic             upd_valid_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i,
   output logic             upd_ready_o,
   output logic             init_done_o,
   output logic             tbl_en_o,
   output logic             tbl_we_o,
   output logic [IDX_W-1:0] tbl_idx_o,
   output logic [1:0]       tbl_wdata_o,
   input  logic [1:0]       tbl_rdata_i
);

   localparam int PTR_W = $clog2(UQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UQ_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UPD_WR = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_armed;        // low only in the first cycle after reset
   logic              r_init_done;
   logic              r_pred_valid;
   logic [IDX_W-1:0]  r_sweep;
   logic [IDX_W-1:0]  r_q_idx [UQ_DEPTH];
   logic [UQ_DEPTH-1:0] r_q_tkn;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_upd_pri;
   logic              w_lkp_grant;
   logic              w_sweep_wr;
   logic [IDX_W-1:0]  w_head_idx;
   logic              w_head_tkn;
   logic [1:0]        w_new_cnt;

   // Saturating 2-bit counter step towards the resolved direction
   function automatic logic [1:0] sat_step(input logic [1:0] old_v, input logic taken);
      logic [1:0] res;
      res = old_v;
      if (taken) begin
         if (old_v != 2'b11) res = old_v + 2'b01;
         else                res = old_v;
      end else begin
         if (old_v != 2'b00) res = old_v - 2'b01;
         else                res = old_v;
      end
      return res;
   endfunction

   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   // Ready ignores a same-cycle pop: a full queue never takes a push
   assign w_push     = upd_valid_i && !w_full;
   assign w_upd_pri  = w_full || (!w_empty && !lkp_valid_i);
   assign w_head_idx = r_q_idx[r_rd_ptr];
   assign w_head_tkn = r_q_tkn[r_rd_ptr];
   assign w_new_cnt  = sat_step(tbl_rdata_i, w_head_tkn);

   assign upd_ready_o  = !w_full;
   assign init_done_o  = r_init_done;
   assign pred_valid_o = r_pred_valid;
   assign pred_taken_o = r_pred_valid & tbl_rdata_i[1];

   // Next-state, port command and grant decode
   always_comb begin
      w_state_nxt = r_state;
      tbl_en_o    = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_idx_o   = '0;
      tbl_wdata_o = 2'b00;
      lkp_ready_o = 1'b0;
      w_lkp_grant = 1'b0;
      w_pop       = 1'b0;
      w_sweep_wr  = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (r_armed) begin
               w_sweep_wr = 1'b1;
               tbl_en_o   = 1'b1;
               tbl_we_o   = 1'b1;
               tbl_idx_o  = r_sweep;
               if (r_sweep == LAST_IDX) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_INIT;
               end
            end else begin
               w_state_nxt = ST_INIT;
            end
         end
         ST_IDLE: begin
            lkp_ready_o = !w_upd_pri;
            if (w_upd_pri) begin
               tbl_en_o    = 1'b1;
               tbl_idx_o   = w_head_idx;
               w_state_nxt = ST_UPD_WR;
            end else if (lkp_valid_i) begin
               tbl_en_o    = 1'b1;
               tbl_idx_o   = lkp_idx_i;
               w_lkp_grant = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_UPD_WR: begin
            // Saturated counters need no write-back, the head retires anyway
            w_pop       = 1'b1;
            w_state_nxt = ST_IDLE;
            if (w_new_cnt != tbl_rdata_i) begin
               tbl_en_o    = 1'b1;
               tbl_we_o    = 1'b1;
               tbl_idx_o   = w_head_idx;
               tbl_wdata_o = w_new_cnt;
            end else begin
               tbl_en_o    = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // Control state, sweep counter and prediction valid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_INIT;
         r_armed      <= 1'b0;
         r_sweep      <= '0;
         r_init_done  <= 1'b0;
         r_pred_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_armed      <= 1'b1;
         r_pred_valid <= w_lkp_grant;
         if (w_sweep_wr) begin
            r_sweep <= r_sweep + IDX_W'(1);
         end
         if (w_sweep_wr && (r_sweep == LAST_IDX)) begin
            r_init_done <= 1'b1;
         end
      end
   end

   // Update FIFO storage, pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_q_tkn  <= '0;
         for (int i = 0; i < UQ_DEPTH; i++) begin
            r_q_idx[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_q_idx[r_wr_ptr] <= upd_idx_i;
            r_q_tkn[r_wr_ptr] <= upd_taken_i;
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_bht_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bht_port_ctrl
// Bench for bht_port_ctrl (IDX_W=4, UQ_DEPTH=4). Contains a storage macro
// model, a behavioural reference (expected table contents, update queue,
// operating mode) compared against the DUT every cycle, directed scenarios
// with hand-computed expectations, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_bht_port_ctrl;

   localparam int IDX_W = 4;
   localparam int UQ    = 4;
   localparam int NENT  = 16;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             lkp_valid_i = 1'b0;
   logic [IDX_W-1:0] lkp_idx_i = '0;
   logic             lkp_ready_o;
   logic             pred_valid_o;
   logic             pred_taken_o;
   logic             upd_valid_i = 1'b0;
   logic [IDX_W-1:0] upd_idx_i = '0;
   logic             upd_taken_i = 1'b0;
   logic             upd_ready_o;
   logic             init_done_o;
   logic             tbl_en_o;
   logic             tbl_we_o;
   logic [IDX_W-1:0] tbl_idx_o;
   logic [1:0]       tbl_wdata_o;
   logic [1:0]       tbl_rdata_i = 2'b11;

   int n_checks = 0;
   int n_errors = 0;

   bht_port_ctrl #(.IDX_W(IDX_W), .UQ_DEPTH(UQ)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .lkp_valid_i(lkp_valid_i), .lkp_idx_i(lkp_idx_i), .lkp_ready_o(lkp_ready_o),
      .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
      .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
      .upd_ready_o(upd_ready_o), .init_done_o(init_done_o),
      .tbl_en_o(tbl_en_o), .tbl_we_o(tbl_we_o), .tbl_idx_o(tbl_idx_o),
      .tbl_wdata_o(tbl_wdata_o), .tbl_rdata_i(tbl_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Storage macro: 1-cycle synchronous read, write on en&we
   logic [1:0] mem [NENT];
   logic [1:0] w7 [$];
   initial begin
      for (int i = 0; i < NENT; i++) mem[i] = 2'($urandom_range(0, 3));
   end
   always @(posedge clk_i) begin
      if (!rst_ni) chk("no_port_in_reset", tbl_en_o, 0);
      if (tbl_en_o) begin
         if (tbl_we_o) begin
            mem[tbl_idx_o] <= tbl_wdata_o;
            if (tbl_idx_o == 4'd7) w7.push_back(tbl_wdata_o);
         end else begin
            tbl_rdata_i <= mem[tbl_idx_o];
         end
      end
   end

   // Reference model: mode, expected table, update queue, pending prediction
   typedef enum int {M_WAIT, M_SWEEP, M_IDLE, M_RMW} mmode_t;
   typedef struct packed { logic [IDX_W-1:0] idx; logic tkn; } upd_t;
   mmode_t     m_mode = M_WAIT;
   int         m_sweep = 0;
   logic [1:0] ref_tbl [NENT];
   upd_t       m_q [$];
   bit         m_done = 0;
   bit         m_pv = 0;
   bit         m_pt = 0;

   always @(negedge clk_i) begin
      logic e_en, e_we, e_lr, e_ur, n_pv, n_pt, push;
      logic [IDX_W-1:0] e_idx;
      logic [1:0] e_wd;
      int old_v, new_v;
      upd_t hd, nw;
      mmode_t n_mode;
      if (!rst_ni) begin
         chk("rst_lkp_ready", lkp_ready_o, 0);
         chk("rst_pred_valid", pred_valid_o, 0);
         chk("rst_upd_ready", upd_ready_o, 1);
         chk("rst_init_done", init_done_o, 0);
         chk("rst_tbl_en", tbl_en_o, 0);
         chk("rst_tbl_idx", tbl_idx_o, 0);
         m_mode = M_WAIT; m_sweep = 0; m_q.delete(); m_done = 0; m_pv = 0; m_pt = 0;
      end else begin
         e_en = 0; e_we = 0; e_lr = 0; e_idx = '0; e_wd = 2'b00;
         n_pv = 0; n_pt = 0; n_mode = m_mode;
         e_ur = (m_q.size() < UQ);
         push = upd_valid_i && e_ur;
         nw.idx = upd_idx_i; nw.tkn = upd_taken_i;
         case (m_mode)
            M_WAIT: n_mode = M_SWEEP;
            M_SWEEP: begin
               e_en = 1; e_we = 1; e_idx = 4'(m_sweep); e_wd = 2'b00;
               ref_tbl[m_sweep] = 2'b00;
               if (m_sweep == NENT - 1) begin n_mode = M_IDLE; m_done = 1; end
               m_sweep++;
            end
            M_IDLE: begin
               if (m_q.size() == UQ || (m_q.size() > 0 && !lkp_valid_i)) begin
                  e_en = 1; e_idx = m_q[0].idx; n_mode = M_RMW;
               end else begin
                  e_lr = 1;
                  if (lkp_valid_i) begin
                     e_en = 1; e_idx = lkp_idx_i;
                     n_pv = 1; n_pt = ref_tbl[lkp_idx_i][1];
                  end
               end
            end
            default: begin
               hd = m_q.pop_front();
               old_v = int'(ref_tbl[hd.idx]);
               if (hd.tkn) new_v = (old_v == 3) ? 3 : old_v + 1;
               else        new_v = (old_v == 0) ? 0 : old_v - 1;
               if (new_v != old_v) begin
                  e_en = 1; e_we = 1; e_idx = hd.idx; e_wd = 2'(new_v);
               end
               ref_tbl[hd.idx] = 2'(new_v);
               n_mode = M_IDLE;
            end
         endcase
         chk("lkp_ready", lkp_ready_o, e_lr);
         chk("upd_ready", upd_ready_o, e_ur);
         chk("init_done", init_done_o, m_done && m_mode != M_SWEEP ? 1 : 0);
         chk("pred_valid", pred_valid_o, m_pv);
         chk("pred_taken", pred_taken_o, m_pv ? m_pt : 0);
         chk("tbl_en", tbl_en_o, e_en);
         if (e_en) begin
            chk("tbl_we", tbl_we_o, e_we);
            chk("tbl_idx", tbl_idx_o, e_idx);
         end
         if (e_we) chk("tbl_wdata", tbl_wdata_o, e_wd);
         if (push) m_q.push_back(nw);
         m_mode = n_mode; m_pv = n_pv; m_pt = n_pt;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Runs from reset release until init_done; optionally pushes two updates to idx 9
   task automatic sweep_check(input bit push_two);
      int nwr, done_cyc;
      bit lr_seen;
      nwr = 0; done_cyc = 0; lr_seen = 0;
      lkp_valid_i = !push_two;
      lkp_idx_i = 4'd2;
      upd_valid_i = push_two; upd_idx_i = 4'd9; upd_taken_i = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         upd_valid_i = push_two && (c < 2);
         if (init_done_o) begin done_cyc = c; break; end
         if (tbl_en_o && tbl_we_o && tbl_wdata_o == 2'b00) nwr++;
         if (lkp_ready_o) lr_seen = 1;
      end
      chk("sweep_done_cycle", done_cyc, 17);
      chk("sweep_writes", nwr, 16);
      chk("sweep_no_lkp_ready", lr_seen, 0);
      if (push_two) begin
         chk("first_idle_rmw_en", tbl_en_o, 1);
         chk("first_idle_rmw_rd", tbl_we_o, 0);
         chk("first_idle_rmw_idx", tbl_idx_o, 9);
      end
      lkp_valid_i = 1'b0;
      upd_valid_i = 1'b0;
   endtask

   initial begin
      int npv, ntk, nlr;
      bit seen_full, found;
      #600_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int npv, ntk, nlr;
      bit seen_full, found;
      rst_ni = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      sweep_check(1'b0);
      repeat (2) step();

      // Back-to-back lookups 3,4,5
      npv = 0; ntk = 0;
      for (int i = 0; i < 6; i++) begin
         lkp_valid_i = (i < 3);
         lkp_idx_i = 4'(3 + i);
         step();
         if (pred_valid_o) npv++;
         if (pred_taken_o) ntk++;
      end
      chk("lkp345_pred_valid_cnt", npv, 3);
      chk("lkp345_pred_taken_cnt", ntk, 0);
      lkp_valid_i = 1'b0;

      // Three taken updates to idx 7
      w7.delete();
      for (int i = 0; i < 3; i++) begin
         upd_valid_i = 1'b1; upd_idx_i = 4'd7; upd_taken_i = 1'b1;
         step();
      end
      upd_valid_i = 1'b0;
      repeat (10) step();
      chk("idx7_write_count", w7.size(), 3);
      for (int i = 0; i < 3; i++) chk("idx7_write_seq", (i < w7.size()) ? w7[i] : 2'b00, i + 1);
      chk("idx7_mem", mem[7], 2'b11);
      lkp_valid_i = 1'b1; lkp_idx_i = 4'd7;
      step();
      lkp_valid_i = 1'b0;
      chk("idx7_pred_valid", pred_valid_o, 1);
      chk("idx7_pred_taken", pred_taken_o, 1);
      w7.delete();
      upd_valid_i = 1'b1; upd_idx_i = 4'd7; upd_taken_i = 1'b1;
      step();
      upd_valid_i = 1'b0;
      repeat (6) step();
      chk("idx7_saturated_no_write", w7.size(), 0);
      chk("idx7_mem_sat", mem[7], 2'b11);

      // Fill the queue under continuous lookup pressure
      nlr = 0; seen_full = 0;
      lkp_valid_i = 1'b1;
      for (int c = 0; c < 14; c++) begin
         lkp_idx_i = 4'($urandom_range(0, 15));
         upd_valid_i = (c < 4); upd_idx_i = 4'(c + 1); upd_taken_i = 1'b1;
         step();
         if (!upd_ready_o) seen_full = 1;
         if (!lkp_ready_o) nlr++;
      end
      chk("fill_seen_full", seen_full, 1);
      chk("fill_lkp_blocked_cycles", nlr, 2);
      chk("fill_ready_back", upd_ready_o, 1);
      upd_valid_i = 1'b0;
      lkp_valid_i = 1'b0;
      repeat (10) step();

      // Reset during the write cycle of an RMW with entries queued
      lkp_valid_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         upd_valid_i = 1'b1; upd_idx_i = 4'(10 + c); upd_taken_i = 1'($urandom_range(0, 1));
         step();
      end
      upd_valid_i = 1'b0;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         if (m_mode == M_RMW) begin found = 1; break; end
         step();
      end
      chk("rmw_reached", found, 1);
      rst_ni = 1'b0;
      #1;
      chk("midrst_tbl_en", tbl_en_o, 0);
      chk("midrst_tbl_we", tbl_we_o, 0);
      chk("midrst_tbl_wdata", tbl_wdata_o, 0);
      chk("midrst_upd_ready", upd_ready_o, 1);
      chk("midrst_lkp_ready", lkp_ready_o, 0);
      chk("midrst_init_done", init_done_o, 0);
      lkp_valid_i = 1'b0;
      step(); step();
      rst_ni = 1'b1;
      sweep_check(1'b1);
      repeat (8) step();
      chk("init_pushes_applied", mem[9], 2'b10);

      // Randomized traffic with one reset in the middle
      for (int i = 0; i < 3000; i++) begin
         lkp_valid_i = ($urandom_range(0, 99) < 60);
         lkp_idx_i = 4'($urandom_range(0, 15));
         upd_valid_i = ($urandom_range(0, 99) < 40);
         upd_idx_i = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         upd_taken_i = 1'($urandom_range(0, 1));
         rst_ni = !(i >= 1500 && i < 1502);
         step();
      end
      lkp_valid_i = 1'b0;
      upd_valid_i = 1'b0;
      repeat (10) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
